// File: rtl/cla_nibble_serial_adder_if.sv
// Request/result handshake bundle for the nibble-serial CLA sequencer.
// master = requester/consumer side, slave = the sequencer.
interface cla_nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_c;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_sum, out_c, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_sum, out_c, out_ovf
    );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// Wide adder built by streaming LSB-first nibbles through an external registered
// 4-bit CLA, chaining its carry-out back as the next nibble's carry-in.
module cla_nibble_serial_adder #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLA_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    cla_nibble_serial_adder_if.slave  bus,
    output logic [3:0]                cla_a,
    output logic [3:0]                cla_b,
    output logic                      cla_c_in,
    input  logic [3:0]                cla_sum,
    input  logic                      cla_c_out,
    output logic                      busy
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned WCW     = (CLA_LAT > 1) ? $clog2(CLA_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;

    state_t           state, state_d;
    logic [IDXW-1:0]  idx;
    logic [WCW-1:0]   wcnt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_c_q, out_ovf_q;

    logic             accept, last_nib, wait_done;
    logic [WIDTH-1:0] merged, a_next, b_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        accept    = (state == IDLE) && bus.in_valid;
        last_nib  = (idx == IDXW'(NIBBLES - 1));
        wait_done = (wcnt == WCW'(CLA_LAT - 1));
        unique case (state)
            IDLE:    if (bus.in_valid) state_d = WAIT;
            WAIT:    if (wait_done) state_d = CAPTURE;
            CAPTURE: state_d = last_nib ? DONE : WAIT;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Final result includes the nibble being captured this cycle, not yet in sum_q.
    always_comb begin
        merged               = sum_q;
        merged[4*idx +: 4]   = cla_sum;
        a_next               = a_q >> (4 * (32'(idx) + 1));
        b_next               = b_q >> (4 * (32'(idx) + 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            wcnt      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cla_a     <= '0;
            cla_b     <= '0;
            cla_c_in  <= 1'b0;
            out_sum_q <= '0;
            out_c_q   <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.in_a;
                        b_q      <= bus.in_b;
                        cla_a    <= bus.in_a[3:0];
                        cla_b    <= bus.in_b[3:0];
                        cla_c_in <= bus.in_c;
                        idx      <= '0;
                        wcnt     <= '0;
                    end
                end
                WAIT: begin
                    if (!wait_done) wcnt <= wcnt + 1'b1;
                end
                CAPTURE: begin
                    sum_q[4*idx +: 4] <= cla_sum;
                    if (!last_nib) begin
                        idx      <= idx + 1'b1;
                        cla_a    <= a_next[3:0];
                        cla_b    <= b_next[3:0];
                        cla_c_in <= cla_c_out;
                        wcnt     <= '0;
                    end else begin
                        out_sum_q <= merged;
                        out_c_q   <= cla_c_out;
                        out_ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (merged[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (state != IDLE);
endmodule
